// File: rtl/systola_pkg.sv
`default_nettype none
// ============================================================================
// Module      : systola_pkg
// Description : Shared types for the systolic array edge logic: operand byte,
//               lane beat records and the skew feeder state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package systola_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] byte_t;

  // Beat for the tail lane: carries the end-of-vector tag alongside the operand
  typedef struct packed {
    logic  fire;
    logic  last;
    byte_t data;
  } lane_beat_t;

  // Beat for every other lane: the end-of-vector tag is only needed on the tail
  typedef struct packed {
    logic  fire;
    byte_t data;
  } edge_beat_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    GAP    = 2'd2
  } feeder_state_e;

endpackage
`default_nettype wire

// File: rtl/skew_delay_line.sv
`default_nettype none
// ============================================================================
// Module      : skew_delay_line
// Description : Fixed-depth shift register of beat records. DEPTH stages, so a
//               beat presented before edge k appears on dout after edge
//               k+DEPTH-1.
// Revision    : 1.0 - initial release
// ============================================================================
module skew_delay_line
  import systola_pkg::*;
#(
  parameter int  DEPTH  = 1,
  parameter type beat_t = lane_beat_t
) (
  input  logic  clk,
  input  logic  rst,
  input  beat_t din,
  output beat_t dout
);

  beat_t [DEPTH-1:0] stage;

  // Shift the beat one stage per cycle; reset flushes every stage
  always_ff @(posedge clk) begin
    if (rst) begin
      stage <= '0;
    end else begin
      stage[0] <= din;
      for (int j = 1; j < DEPTH; j++) begin
        stage[j] <= stage[j-1];
      end
    end
  end

  assign dout = stage[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : skew_feeder
// Description : Systolic array edge feeder. Accepts one LANES-wide vector beat
//               per cycle, skews lane i by i cycles, produces per-lane fire
//               strobes and guarantees a fire-low gap between vectors.
// Revision    : 1.0 - initial release
// ============================================================================
module skew_feeder
  import systola_pkg::*;
#(
  parameter int LANES = 4,
  parameter int CNTW  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [LANES*DATA_W-1:0] s_data,
  input  logic                    s_last,
  output logic [LANES-1:0]        m_fire,
  output logic [LANES*DATA_W-1:0] m_data,
  output logic                    vec_done,
  output logic [CNTW-1:0]         vec_count,
  output logic                    err_bubble
);

  feeder_state_e   state;
  feeder_state_e   state_next;
  logic            ready_fsm;
  logic            bubble;
  logic            xfer;
  logic            tail_last;
  logic            done_q;
  logic [CNTW-1:0] count_q;
  logic            err_q;

  // Feeder state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode; GAP withholds ready for one cycle so
  // every lane sees a fire-low cycle between consecutive vectors
  always_comb begin
    state_next = state;
    ready_fsm  = 1'b0;
    bubble     = 1'b0;
    case (state)
      IDLE: begin
        ready_fsm = 1'b1;
        if (s_valid) begin
          state_next = s_last ? GAP : STREAM;
        end
      end
      STREAM: begin
        ready_fsm = 1'b1;
        if (s_valid) begin
          if (s_last) begin
            state_next = GAP;
          end
        end else begin
          // Valid dropped mid-vector: the injected fire-low closes the
          // vector early in the PEs, so start over from IDLE
          bubble     = 1'b1;
          state_next = IDLE;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Reset holds ready low so nothing is accepted while the lanes are flushed
  assign s_ready = ready_fsm & ~rst;
  assign xfer    = s_valid & s_ready;

  // One delay line per lane; lane i is i+1 stages deep. Idle cycles inject a
  // zero beat so m_data is zero whenever fire is low.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    if (i == LANES-1) begin : g_tail
      lane_beat_t din;
      lane_beat_t dout;

      assign din = '{fire: xfer,
                     last: xfer & s_last,
                     data: xfer ? s_data[DATA_W*i +: DATA_W] : byte_t'(0)};

      skew_delay_line #(
        .DEPTH  (i + 1),
        .beat_t (lane_beat_t)
      ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout)
      );

      assign m_fire[i]                   = dout.fire;
      assign m_data[DATA_W*i +: DATA_W]  = dout.data;
      assign tail_last                   = dout.last;
    end else begin : g_body
      edge_beat_t din;
      edge_beat_t dout;

      assign din = '{fire: xfer,
                     data: xfer ? s_data[DATA_W*i +: DATA_W] : byte_t'(0)};

      skew_delay_line #(
        .DEPTH  (i + 1),
        .beat_t (edge_beat_t)
      ) u_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (din),
        .dout (dout)
      );

      assign m_fire[i]                  = dout.fire;
      assign m_data[DATA_W*i +: DATA_W] = dout.data;
    end
  end

  // Completion tracking: the tail-lane last tag marks the final fire of a
  // vector; one more register lands the pulse on the first fire-low cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      done_q  <= 1'b0;
      count_q <= '0;
    end else begin
      done_q <= tail_last;
      if (tail_last) begin
        count_q <= count_q + 1'b1;
      end
    end
  end

  // Sticky bubble flag, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (bubble) begin
      err_q <= 1'b1;
    end
  end

  assign vec_done   = done_q;
  assign vec_count  = count_q;
  assign err_bubble = err_q;

endmodule
`default_nettype wire

// File: tb/tb_skew_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_skew_feeder
// Description : Self-checking bench for skew_feeder. Keeps an acceptance
//               history per edge and derives every expected output from it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_skew_feeder;

  localparam int LANES = 4;
  localparam int CNTW  = 8;
  localparam int MAXE  = 8192;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 s_valid;
  logic                 s_ready;
  logic [LANES*8-1:0]   s_data;
  logic                 s_last;
  logic [LANES-1:0]     m_fire;
  logic [LANES*8-1:0]   m_data;
  logic                 vec_done;
  logic [CNTW-1:0]      vec_count;
  logic                 err_bubble;

  always #5 clk = ~clk;

  skew_feeder #(.LANES(LANES), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .s_last     (s_last),
    .m_fire     (m_fire),
    .m_data     (m_data),
    .vec_done   (vec_done),
    .vec_count  (vec_count),
    .err_bubble (err_bubble)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference: what was accepted at each edge, and since when history is valid
  int              n        = -1;
  int              last_rst = -1;
  bit              acc_fire [MAXE];
  bit              acc_last [MAXE];
  logic [31:0]     acc_data [MAXE];
  bit              gap_m;
  bit              open_m;
  bit              err_m;
  bit              done_m;
  logic [CNTW-1:0] cnt_m;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check ready, advance the model, check outputs
  task automatic step(input bit r, input bit v, input bit l, input logic [31:0] d);
    bit              ready_exp;
    bit              acc;
    logic [LANES-1:0] exp_fire;
    logic [31:0]     exp_data;
    rst     = r;
    s_valid = v;
    s_last  = l;
    s_data  = d;
    #1;
    ready_exp = !r && !gap_m;
    chk("s_ready", s_ready, ready_exp);
    @(posedge clk);
    n++;
    if (r) begin
      last_rst    = n;
      acc_fire[n] = 0;
      acc_last[n] = 0;
      acc_data[n] = '0;
      gap_m  = 0;
      open_m = 0;
      err_m  = 0;
      done_m = 0;
      cnt_m  = '0;
    end else begin
      acc         = v && ready_exp;
      acc_fire[n] = acc;
      acc_last[n] = acc && l;
      acc_data[n] = acc ? d : 32'h0;
      if (acc) begin
        gap_m  = l;
        open_m = !l;
      end else begin
        gap_m = 0;
        if (open_m && !v) begin
          err_m  = 1;
          open_m = 0;
        end
      end
      done_m = (n - LANES > last_rst) && acc_last[n - LANES];
      if (done_m) cnt_m = cnt_m + 1'b1;
    end
    #1;
    exp_fire = '0;
    exp_data = '0;
    for (int i = 0; i < LANES; i++) begin
      int k;
      k = n - i;
      if (k > last_rst && acc_fire[k]) begin
        exp_fire[i]       = 1'b1;
        exp_data[8*i +: 8] = acc_data[k][8*i +: 8];
      end
    end
    chk("m_fire", m_fire, exp_fire);
    chk("m_data", m_data, exp_data);
    chk("vec_done", vec_done, done_m);
    chk("vec_count", vec_count, cnt_m);
    chk("err_bubble", err_bubble, err_m);
  endtask

  task automatic idle(input int cycles);
    for (int c = 0; c < cycles; c++) step(0, 0, 0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    gap_m = 0; open_m = 0; err_m = 0; done_m = 0; cnt_m = '0;

    // Reset state
    step(1, 0, 0, 32'h0);
    step(1, 1, 1, 32'hDEADBEEF);

    // 1: three-beat vector, done after edge k_last+4
    step(0, 1, 0, 32'h04030201);
    step(0, 1, 0, 32'h08070605);
    step(0, 1, 1, 32'h0C0B0A09);
    idle(6);
    chk("t1_count", vec_count, 1);

    // 2: two back-to-back two-beat vectors with valid held high
    step(0, 1, 0, 32'h11111111);
    step(0, 1, 1, 32'h22222222);
    step(0, 1, 0, 32'h33333333);   // gap cycle: not taken
    step(0, 1, 0, 32'h33333333);
    step(0, 1, 1, 32'h44444444);
    step(0, 1, 0, 32'h55555555);   // gap cycle
    idle(6);
    chk("t2_count", vec_count, 3);

    // 3: 256 single-beat vectors, count wraps back to the same value
    for (int j = 0; j < 512; j++) step(0, 1, 1, $urandom);
    idle(6);
    chk("t3_wrap", vec_count, 3);

    // 4: bubble mid-vector, then a fresh vector completes
    step(0, 1, 0, 32'hA1A2A3A4);
    step(0, 0, 0, 32'h0);
    step(0, 1, 0, 32'hB1B2B3B4);
    step(0, 1, 0, 32'hC1C2C3C4);
    step(0, 1, 1, 32'hD1D2D3D4);
    idle(6);
    chk("t4_err", err_bubble, 1);
    chk("t4_count", vec_count, 4);

    // 5: reset while lanes hold live beats
    step(0, 1, 0, 32'h01020304);
    step(0, 1, 0, 32'h05060708);
    step(0, 1, 1, 32'h090A0B0C);
    step(1, 1, 0, 32'h0);
    idle(6);
    chk("t5_count", vec_count, 0);

    // 6: s_last without s_valid is ignored
    step(0, 0, 1, 32'hFFFFFFFF);
    step(0, 0, 1, 32'hFFFFFFFF);
    idle(5);

    // Randomized traffic with occasional resets
    for (int j = 0; j < 1500; j++) begin
      step($urandom_range(99) == 0, $urandom_range(3) != 0,
           $urandom_range(2) == 0, $urandom);
    end
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
